// File: rtl/fios_pkg.sv
// Shared types for the FIOS Montgomery datapath.
// Word width is tied to the DSP operand size.
package fios_pkg;

  localparam int WORD_W = 17;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DECIDE,
    DRAIN
  } collector_state_t;

endpackage

// File: rtl/fios_sub_word.sv
// One word of a ripple subtract: d = a - b - bin.
// bout is set when a < b + bin.
module fios_sub_word
  import fios_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  logic  bin,
  output word_t d,
  output logic  bout
);

  logic [WORD_W:0] w_diff;

  assign w_diff = {1'b0, a} - {1'b0, b}
                - {{WORD_W{1'b0}}, bin};
  assign d      = w_diff[WORD_W-1:0];
  assign bout   = w_diff[WORD_W];

endmodule

// File: rtl/fios_res_collector.sv
// Captures FIOS result words, subtracts p on the fly,
// then streams T or T-p out LSW first.
module fios_res_collector
  import fios_pkg::*;
#(
  parameter int N_WORDS = 16,
  parameter int WORD_W  = 17
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic              res_valid_i,
  input  logic [WORD_W-1:0] res_i,
  input  logic [WORD_W-1:0] p_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WORD_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int KW = $clog2(N_WORDS);
  localparam logic [KW-1:0] LAST = KW'(N_WORDS - 1);

  collector_state_t r_state;
  collector_state_t w_state_nx;

  logic [KW-1:0] r_k;
  logic          r_borrow;
  logic          r_sel;
  logic          r_err;
  word_t         r_t [N_WORDS];
  word_t         r_d [N_WORDS];

  word_t w_d;
  logic  w_bout;
  logic  w_cap;
  logic  w_hs;
  logic  w_drop;

  fios_sub_word u_sub (
    .a    (res_i),
    .b    (p_i),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_cap  = (r_state == COLLECT) & res_valid_i;
  assign w_hs   = (r_state == DRAIN) & out_ready_i;
  assign w_drop = res_valid_i
                & ((r_state == DECIDE) | (r_state == DRAIN));

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    if (start_i) w_state_nx = COLLECT;
      COLLECT: if (w_cap && r_k == LAST) w_state_nx = DECIDE;
      DECIDE:  w_state_nx = DRAIN;
      DRAIN:   if (w_hs && r_k == LAST) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state  <= IDLE;
      r_k      <= '0;
      r_borrow <= 1'b0;
      r_sel    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == IDLE && start_i) begin
        r_k      <= '0;
        r_borrow <= 1'b0;
        r_err    <= 1'b0;
      end
      if (w_cap) begin
        r_k      <= r_k + 1'b1;
        r_borrow <= w_bout;
      end
      // No borrow out of the top word means T >= p.
      if (r_state == DECIDE) begin
        r_sel <= ~r_borrow;
        r_k   <= '0;
      end
      if (w_hs) r_k <= r_k + 1'b1;
      if (w_drop) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (w_cap) begin
      r_t[r_k] <= res_i;
      r_d[r_k] <= w_d;
    end
  end

  assign out_valid_o = (r_state == DRAIN);
  assign out_data_o  = !out_valid_o ? '0
                     : r_sel ? r_d[r_k] : r_t[r_k];
  assign out_last_o  = out_valid_o & (r_k == LAST);
  assign busy_o      = (r_state != IDLE);
  assign err_o       = r_err;

endmodule

// File: tb/tb_fios_res_collector.sv
// Scoreboard bench for fios_res_collector with N_WORDS=4.
// Expected words come from whole-number arithmetic on T and p.
module tb_fios_res_collector;

  localparam int NW = 4;
  localparam int WW = 17;
  localparam int TW = NW * WW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          rv = 1'b0;
  logic [WW-1:0] res = '0;
  logic [WW-1:0] pw = '0;
  logic          ready = 1'b0;
  logic          out_valid;
  logic [WW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          err;

  fios_res_collector #(.N_WORDS(NW), .WORD_W(WW)) dut (
    .clock_i     (clk),
    .reset_n_i   (rst_n),
    .start_i     (start),
    .res_valid_i (rv),
    .res_i       (res),
    .p_i         (pw),
    .out_valid_o (out_valid),
    .out_ready_i (ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .busy_o      (busy),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int hs_cnt = 0;
  bit rand_ready = 1'b0;
  bit held = 1'b0;
  logic [WW:0] held_val;
  logic [WW:0] expq [$];

  logic [WW-1:0] P [NW] =
    '{17'h1ABCD, 17'h00001, 17'h0FFFF, 17'h10000};
  logic [TW-1:0] p_int;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic push_expected(input logic [TW-1:0] t);
    logic [TW-1:0] r;
    r = (t >= p_int) ? t - p_int : t;
    for (int i = 0; i < NW; i++)
      expq.push_back({(i == NW - 1), r[i*WW +: WW]});
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (held)
        chk("hold_stable", {out_last, out_data}, held_val);
      if (ready) begin
        hs_cnt++;
        held = 1'b0;
        if (expq.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_out: got %0h want none",
                   out_data);
        end else begin
          chk("out_word", {out_last, out_data},
              expq.pop_front());
        end
      end else begin
        held = 1'b1;
        held_val = {out_last, out_data};
      end
    end else begin
      held = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [TW-1:0] t,
                      input bit gaps,
                      input int nsend);
    @(posedge clk);
    #1 start = 1'b1;
    rv  = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
    res = WW'($urandom);
    pw  = WW'($urandom);
    tick();
    start = 1'b0;
    rv = 1'b0;
    chk("err_clear", err, 0);
    chk("busy_rise", busy, 1);
    for (int i = 0; i < nsend; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) tick();
      end
      rv  = 1'b1;
      res = t[i*WW +: WW];
      pw  = P[i];
      if (i == NW - 1) push_expected(t);
      tick();
      rv = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      tick();
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_data"}, out_data, 0);
    chk({nm, "_last"}, out_last, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_err"}, err, 0);
  endtask

  initial begin
    int h0;
    logic [TW-1:0] t;
    for (int i = 0; i < NW; i++) p_int[i*WW +: WW] = P[i];

    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // T = p-1: passes through, 4 back-to-back words
    ready = 1'b1;
    h0 = hs_cnt;
    send(p_int - 1, 1'b0, NW);
    chk("decide_valid", out_valid, 0);
    tick();
    chk("latency_valid", out_valid, 1);
    tick();
    tick();
    tick();
    chk("busy_before_end", busy, 1);
    tick();
    chk("busy_fall", busy, 0);
    chk("burst_hs", hs_cnt - h0, 4);

    // T = p: all-zero output
    send(p_int, 1'b0, NW);
    wait_idle();

    // T >= p with carries crossing every word
    send(p_int + TW'(17'h1FFFF), 1'b1, NW);
    wait_idle();
    send(p_int + (TW'(1) << (3 * WW)) - 1, 1'b1, NW);
    wait_idle();

    // backpressure on word 1
    h0 = hs_cnt;
    send(p_int - 1, 1'b0, NW);
    tick();
    tick();
    ready = 1'b0;
    repeat (3) tick();
    ready = 1'b1;
    wait_idle();
    chk("bp_hs", hs_cnt - h0, 4);

    // stray word in IDLE is ignored
    rv = 1'b1;
    tick();
    rv = 1'b0;
    chk("idle_rv_err", err, 0);
    chk("idle_rv_busy", busy, 0);

    // stray word and start during DRAIN
    ready = 1'b0;
    send(p_int + TW'(5), 1'b0, NW);
    tick();
    rv = 1'b1;
    res = '1;
    tick();
    rv = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("drop_err", err, 1);
    ready = 1'b1;
    wait_idle();
    chk("err_sticky", err, 1);
    send(p_int - TW'(7), 1'b0, NW);
    wait_idle();

    // reset after two input words
    send(p_int, 1'b0, 2);
    rst_n = 1'b0;
    #1 chk_zero("abort_collect");
    tick();
    rst_n = 1'b1;
    tick();

    // reset while draining with err set
    ready = 1'b0;
    send(p_int + TW'(9), 1'b0, NW);
    tick();
    rv = 1'b1;
    tick();
    rv = 1'b0;
    chk("pre_abort_valid", out_valid, 1);
    rst_n = 1'b0;
    expq.delete();
    #1 chk_zero("abort_drain");
    tick();
    rst_n = 1'b1;
    ready = 1'b1;
    tick();
    send(p_int + TW'(17'h1ABCC), 1'b0, NW);
    wait_idle();

    // random results, random gaps and backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 30; n++) begin
      int m;
      m = $urandom_range(0, 3);
      case (m)
        0: t = TW'({$urandom, $urandom, $urandom});
        1: t = p_int + TW'($urandom_range(0, 5000));
        2: t = p_int - TW'($urandom_range(1, 5000));
        default: t = p_int + TW'({$urandom, $urandom}) % p_int;
      endcase
      send(t, 1'b1, NW);
      wait_idle();
    end
    rand_ready = 1'b0;
    tick();
    ready = 1'b1;
    tick();
    chk("queue_empty", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
